// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_subtractor_ctrl_pkg

// File: rtl/serial_subtractor_ctrl_fs_cell.sv
// One-bit combinational full subtractor: d = a - b - bin, with borrow out.
module serial_subtractor_ctrl_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : serial_subtractor_ctrl_fs_cell

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first,
// registered borrow chain, valid/ready handshake on operands and result.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  // A one-bit counter is still needed when WIDTH is 1 ($clog2(1) is 0).
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;

  logic             d_bit_s;
  logic             b_next_s;

  serial_subtractor_ctrl_fs_cell u_fs_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (d_bit_s),
    .bout (b_next_s)
  );

  // Next-state and datapath update: load in IDLE, shift in RUN, hold in DONE.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Result bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
        diff_d              = diff_q >> 1;
        diff_d[WIDTH-1]     = d_bit_s;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        borrow_d            = b_next_s;
        cnt_d               = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          bout_d  = b_next_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;

endmodule : serial_subtractor_ctrl

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed testbench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor_ctrl;

  logic       clk;
  logic       rst_n;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, bout8, busy8;
  logic [7:0] a8, b8, diff8;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, bout1, busy1;
  logic [0:0] a1, b1, diff1;

  int n_tests;
  int n_fail;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .diff      (diff8),
    .bout      (bout8),
    .busy      (busy8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .diff      (diff1),
    .bout      (bout1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full WIDTH=8 transaction: accept, count latency, check result, hand off.
  task automatic run_op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] exp_d, input logic exp_b);
    int  edges;
    bit  ready_seen;
    check_eq({tag, "_in_ready_idle"}, 32'(in_ready8), 32'd1);
    a8 = av;
    b8 = bv;
    in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    edges = 0;
    ready_seen = 1'b0;
    while (!out_valid8 && edges < 20) begin
      if (in_ready8) ready_seen = 1'b1;
      tick();
      edges++;
    end
    if (in_ready8) ready_seen = 1'b1;
    check_eq({tag, "_latency"}, 32'(edges), 32'd8);
    check_eq({tag, "_in_ready_low"}, 32'(ready_seen), 32'd0);
    check_eq({tag, "_diff"}, 32'(diff8), 32'(exp_d));
    check_eq({tag, "_bout"}, 32'(bout8), 32'(exp_b));
    // Operands offered during the handoff edge must not be taken.
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check_eq({tag, "_handoff_idle"}, {30'd0, busy8, out_valid8}, 32'd0);
    in_valid8 = 1'b0;
    tick();
    check_eq({tag, "_no_same_edge_accept"}, 32'(in_ready8), 32'd1);
  endtask

  // WIDTH=1 transaction: one RUN edge then DONE.
  task automatic run_op1(input string tag, input logic av, input logic bv,
                         input logic exp_d, input logic exp_b);
    a1 = av;
    b1 = bv;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check_eq({tag, "_run"}, {30'd0, busy1, out_valid1}, 32'd2);
    tick();
    check_eq({tag, "_valid"}, 32'(out_valid1), 32'd1);
    check_eq({tag, "_diff"}, 32'(diff1), 32'(exp_d));
    check_eq({tag, "_bout"}, 32'(bout1), 32'(exp_b));
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check_eq({tag, "_idle"}, 32'(in_ready1), 32'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready8), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid8), 32'd0);
    check_eq("rst_busy", 32'(busy8), 32'd0);
    check_eq("rst_diff", 32'(diff8), 32'h00);
    check_eq("rst_bout", 32'(bout8), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op8("op_200_55", 8'd200, 8'd55, 8'h91, 1'b0);
    run_op8("op_55_200", 8'd55, 8'd200, 8'h6F, 1'b1);
    run_op8("op_0_1", 8'h00, 8'h01, 8'hFF, 1'b1);
    run_op8("op_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0);

    // Back-pressure: hold DONE for 5 cycles while new operands are offered.
    a8 = 8'd200; b8 = 8'd55; in_valid8 = 1'b1;
    tick();
    a8 = 8'h01; b8 = 8'h02;
    for (int i = 0; i < 8; i++) tick();
    check_eq("bp_enter_done", 32'(out_valid8), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check_eq("bp_out_valid", 32'(out_valid8), 32'd1);
    check_eq("bp_diff", 32'(diff8), 32'h91);
    check_eq("bp_bout", 32'(bout8), 32'd0);
    check_eq("bp_in_ready", 32'(in_ready8), 32'd0);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check_eq("bp_release", 32'(in_ready8), 32'd1);

    // Reset after 3 RUN edges aborts the operation.
    a8 = 8'd55; b8 = 8'd200; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("abort_busy_before", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_in_ready", 32'(in_ready8), 32'd1);
    check_eq("abort_out_valid", 32'(out_valid8), 32'd0);
    check_eq("abort_diff", 32'(diff8), 32'h00);
    check_eq("abort_bout", 32'(bout8), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid8) check_eq("abort_no_pulse", 32'(out_valid8), 32'd0);
    end
    run_op8("op_10_01", 8'h10, 8'h01, 8'h0F, 1'b0);

    // WIDTH=1 corner cases.
    run_op1("w1_0_1", 1'b0, 1'b1, 1'b1, 1'b1);
    run_op1("w1_1_1", 1'b1, 1'b1, 1'b0, 1'b0);
    run_op1("w1_1_0", 1'b1, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_subtractor_ctrl
